// File: rtl/ram_dp.sv
// ram_dp: true dual-port RAM with byte-lane write enables, configurable read
// latency (1 or 2), selectable same-port read-during-write behaviour and an
// optional hardware zero-fill engine that runs after reset.
//
// Ports (p = a or b):
//   clk, rst         : single rising-edge clock, asynchronous active-high reset
//   p_ena            : port enable; gates both read and write
//   p_rd, p_wr       : read / write requests
//   p_be             : byte-lane write enables (DATA_W/8 bits)
//   p_addr, p_din    : word address and write data
//   p_dout, p_valid  : read data and its one-cycle valid pulse
//   busy             : zero-fill running; port requests are ignored
module ram_dp #(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 8,
  parameter int RD_LAT         = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_ena,
  input  logic                a_rd,
  input  logic                a_wr,
  input  logic [DATA_W/8-1:0] a_be,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_din,
  output logic [DATA_W-1:0]   a_dout,
  output logic                a_valid,
  input  logic                b_ena,
  input  logic                b_rd,
  input  logic                b_wr,
  input  logic [DATA_W/8-1:0] b_be,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_din,
  output logic [DATA_W-1:0]   b_dout,
  output logic                b_valid,
  output logic                busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              clr_we;

  // Both ports packed into index 0 (a) and 1 (b) so the per-port datapath
  // can be generated once.
  logic [1:0]                 ena_w, rd_w, wr_w;
  logic [1:0]                 we, re;
  logic [1:0][NB-1:0]         be;
  logic [1:0][ADDR_W-1:0]     addr;
  logic [1:0][DATA_W-1:0]     din;
  logic [1:0][DATA_W-1:0]     ram_rd;
  logic [1:0][DATA_W-1:0]     dout;
  logic [1:0]                 valid;

  assign ena_w = {b_ena, a_ena};
  assign rd_w  = {b_rd, a_rd};
  assign wr_w  = {b_wr, a_wr};
  assign be    = {b_be, a_be};
  assign addr  = {b_addr, a_addr};
  assign din   = {b_din, a_din};

  // ---------------------------------------------------------------------
  // Zero-fill FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      // Last word written this cycle: leave CLEAR, counter stays put.
      if (clr_cnt_q == {ADDR_W{1'b1}}) begin
        state_d = ST_READY;
      end else begin
        clr_cnt_d = clr_cnt_q + 1'b1;
      end
    end
  end

  assign busy   = (state_q == ST_CLEAR);
  // Memory is never touched while reset is held, so with the fill engine
  // disabled the contents survive reset untouched.
  assign clr_we = busy && !rst;

  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    assign we[gi] = !busy && !rst && ena_w[gi] && wr_w[gi];
    assign re[gi] = !busy && !rst && ena_w[gi] && rd_w[gi];
  end

  // ---------------------------------------------------------------------
  // Storage: one 8-bit RAM per byte lane. Port b is applied before port a
  // so that on an address collision a's enabled lanes win while b's other
  // lanes still land. Reads are read-first (old word) at the array.
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_a_q, rd_b_q;

    always_ff @(posedge clk) begin
      if (clr_we) begin
        mem[clr_cnt_q] <= 8'h00;
      end else begin
        if (we[1] && be[1][gi]) mem[addr[1]] <= din[1][gi*8 +: 8];
        if (we[0] && be[0][gi]) mem[addr[0]] <= din[0][gi*8 +: 8];
      end
      if (re[0]) rd_a_q <= mem[addr[0]];
      if (re[1]) rd_b_q <= mem[addr[1]];
    end

    assign ram_rd[0][gi*8 +: 8] = rd_a_q;
    assign ram_rd[1][gi*8 +: 8] = rd_b_q;
  end

  // ---------------------------------------------------------------------
  // Per-port read pipeline
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic              wf_q;
    logic [DATA_W-1:0] wdin_q;
    logic [NB-1:0]     wbe_q;
    logic [DATA_W-1:0] merged;
    logic              v1_q;

    // Capture this port's own write alongside the read so write-first mode
    // can overlay the new lanes onto the old word read from the array.
    always_ff @(posedge clk) begin
      if (re[gi]) begin
        wf_q   <= (RDW_MODE == 1) && we[gi];
        wdin_q <= din[gi];
        wbe_q  <= be[gi];
      end
    end

    always_comb begin
      merged = ram_rd[gi];
      if (wf_q) begin
        for (int i = 0; i < NB; i++) begin
          if (wbe_q[i]) merged[i*8 +: 8] = wdin_q[i*8 +: 8];
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) v1_q <= 1'b0;
      else     v1_q <= re[gi];
    end

    if (RD_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] out_q;
      logic              v2_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_q <= '0;
          v2_q  <= 1'b0;
        end else begin
          v2_q <= v1_q;
          if (v1_q) out_q <= merged;
        end
      end

      assign dout[gi]  = out_q;
      assign valid[gi] = v2_q;
    end else begin : g_lat1
      // The lane registers only load on a read, so they already hold the
      // last result; this flag forces zero from reset until the next read.
      logic zero_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)         zero_q <= 1'b1;
        else if (re[gi]) zero_q <= 1'b0;
      end

      assign dout[gi]  = zero_q ? '0 : merged;
      assign valid[gi] = v1_q;
    end
  end

  assign a_dout  = dout[0];
  assign a_valid = valid[0];
  assign b_dout  = dout[1];
  assign b_valid = valid[1];

endmodule

// File: doc/ram_dp.md
RAM_DP -- requirements
Module: ram_dp

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, address width; depth is 2**ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 8, word width; must be a multiple of 8.
REQ-003 SHALL have parameter RD_LAT, default 1, read latency in cycles; legal values are 1 and 2.
REQ-004 SHALL have parameter RDW_MODE, default 0, same-port read-during-write behaviour; 0 = read-first, 1 = write-first.
REQ-005 SHALL have parameter CLEAR_ON_RESET, default 1; 1 enables the hardware zero-fill engine.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have, for each port p in {a, b}, port p_ena, input, 1 bit: port enable.
REQ-009 SHALL have p_rd, input, 1 bit: read request.
REQ-010 SHALL have p_wr, input, 1 bit: write request.
REQ-011 SHALL have p_be, input, DATA_W/8 bits: byte-lane write enables.
REQ-012 SHALL have p_addr, input, ADDR_W bits: word address.
REQ-013 SHALL have p_din, input, DATA_W bits: write data.
REQ-014 SHALL have p_dout, output, DATA_W bits: read data.
REQ-015 SHALL have p_valid, output, 1 bit: p_dout carries a new read result this cycle.
REQ-016 SHALL have port busy, output, 1 bit: zero-fill in progress and port accesses are ignored.

Function
REQ-017 SHALL implement a two-state FSM with states CLEAR and READY.
REQ-018 SHALL enter CLEAR on reset when CLEAR_ON_RESET=1, and READY otherwise.
REQ-019 In CLEAR, SHALL write zero to one word per cycle, starting at address 0 with an incrementing counter; busy=1.
REQ-020 SHALL move from CLEAR to READY in the cycle after address 2**ADDR_W-1 is written; the total clear time is 2**ADDR_W cycles, and the counter does not wrap.
REQ-021 While busy=1, SHALL ignore all p_rd and p_wr: no memory write from the ports, and p_valid=0.
REQ-022 In READY, SHALL perform a write when p_ena=1 and p_wr=1.
REQ-023 A write SHALL update only byte lanes whose p_be bit is 1; p_be=0 leaves memory unchanged.
REQ-024 In READY, SHALL perform a read when p_ena=1 and p_rd=1.
REQ-025 A read SHALL present p_dout together with p_valid=1 exactly RD_LAT cycles after the request edge.
REQ-026 p_valid SHALL be a one-cycle pulse per read; back-to-back reads give one result per cycle.
REQ-027 p_dout SHALL hold its last value when no new read completes.
REQ-028 For a same-port rd and wr to the same address, RDW_MODE=0 SHALL return the old word.
REQ-029 For a same-port rd and wr to the same address, RDW_MODE=1 SHALL return the byte-merged new word.
REQ-030 A read on one port of an address written by the other port in the same cycle SHALL return the old word, in both modes.
REQ-031 If both ports write the same address in the same cycle, SHALL apply port a's enabled lanes; port b's lanes not enabled by a_be still apply.
REQ-032 p_ena=0 SHALL suppress both read and write on that port, regardless of p_rd and p_wr.
REQ-033 When RD_LAT=2, SHALL pipeline the output register with no stall; a read issued at cycle n completes at n+2 independently of later requests.

Reset
REQ-034 While rst=1, SHALL set p_dout=0, p_valid=0, and the pipeline valid bits to 0.
REQ-035 While rst=1, SHALL set the clear counter to 0, and busy=1 if CLEAR_ON_RESET=1, else busy=0.
REQ-036 Reset asserted mid-clear SHALL restart the clear at address 0; reset in READY SHALL discard in-flight reads and, with CLEAR_ON_RESET=1, re-zero the memory.
REQ-037 With CLEAR_ON_RESET=0, memory contents SHALL be unspecified after reset and SHALL NOT be modified by reset.

Verification
REQ-038 Zero-fill test (ADDR_W=4): release rst -> busy=1 for exactly 16 cycles; then read every address -> 0x00 each. A write issued during busy -> no effect.
REQ-039 Byte-enable test (DATA_W=16): write 0xFFFF to addr 3; then write 0x1234 with be=2'b01 -> read addr 3 = 0xFF34 with valid at RD_LAT.
REQ-040 Read-during-write test: addr 5=0xAA, same-port rd+wr 0x55 -> RDW_MODE=0 returns 0xAA, RDW_MODE=1 returns 0x55; the cross-port read returns 0xAA in both modes.
REQ-041 Collision test: a writes 0x11, b writes 0x22 to addr 7 in the same cycle with full be -> addr 7 = 0x11.
REQ-042 Latency test (RD_LAT=2): reads of addr 0,1,2 on consecutive cycles -> valid pulses on cycles n+2, n+3, n+4 with the matching data; p_ena=0 read -> no valid.
REQ-043 Reset test: assert rst at clear address 9 -> busy stays 1 and the fill restarts at 0. Assert rst with a read in flight -> valid never rises for it, and dout=0.
